// File: rtl/serial_mod3_tx_pkg.sv
// -----------------------------------------------------------------------------
// serial_mod3_tx_pkg
// Definitions shared by the mod-3 serial transmitter and its matching receiver:
//   - FSM state encodings (IDLE, DATA, CHK1, CHK0)
//   - residue constants R0/R1/R2
//   - mod3_next(r, b): the residue transition r' = (2r + b) mod 3
// -----------------------------------------------------------------------------
package serial_mod3_tx_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_CHK1 = 2'd2;
   localparam logic [1:0] S_CHK0 = 2'd3;

   localparam logic [1:0] R0 = 2'd0;
   localparam logic [1:0] R1 = 2'd1;
   localparam logic [1:0] R2 = 2'd2;

   // Residue update for one more bit appended below the current value.
   // Encoding 3 is unreachable; it falls back to R0 so the tracker self-heals.
   function automatic logic [1:0] mod3_next(input logic [1:0] r, input logic b);
      logic [1:0] n;
      case (r)
         R0:      n = b ? R1 : R0;
         R1:      n = b ? R0 : R2;
         R2:      n = b ? R2 : R1;
         default: n = R0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/serial_mod3_tx_residue.sv
// -----------------------------------------------------------------------------
// mod3_residue
// Registered mod-3 residue tracker.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset (residue -> 0)
//   i_clear    force residue to 0 (takes priority over i_enable)
//   i_enable   fold i_bit into the residue this cycle
//   i_bit      serial bit to fold in
//   o_residue  current residue (0..2)
// -----------------------------------------------------------------------------
module mod3_residue
   import serial_mod3_tx_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_clear,
   input  logic       i_enable,
   input  logic       i_bit,
   output logic [1:0] o_residue
);

   logic [1:0] r_residue;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_residue <= R0;
      end else if (i_clear) begin
         r_residue <= R0;
      end else if (i_enable) begin
         r_residue <= mod3_next(r_residue, i_bit);
      end
   end

   assign o_residue = r_residue;

endmodule

// File: rtl/serial_mod3_tx.sv
// -----------------------------------------------------------------------------
// serial_mod3_tx
// Loads a WIDTH-bit word on a valid/ready handshake, shifts it out MSB-first
// (one bit per accepted beat), then appends the 2-bit mod-3 residue of the
// data bits as a check trailer (residue bit 1, then bit 0).
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   load_valid  load_data is valid
//   load_ready  block can accept a word (IDLE only)
//   load_data   word to transmit, MSB sent first
//   out         current serial bit
//   out_valid   out holds a valid bit
//   out_ready   sink accepts out this cycle
//   out_check   current bit is a trailer bit
//   out_last    current bit is the final trailer bit
//   residue     residue of data bits accepted so far in this frame
// All outputs are registered.
// -----------------------------------------------------------------------------
module serial_mod3_tx
   import serial_mod3_tx_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic             out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_check,
   output logic             out_last,
   output logic [1:0]       residue
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_count;
   logic             r_out;
   logic             r_out_valid;
   logic             r_out_check;
   logic             r_out_last;
   logic             r_load_ready;

   logic             w_accept;
   logic             w_beat;
   logic             w_res_en;
   logic [1:0]       w_residue;
   logic [1:0]       w_res_next;

   // load_ready is high exactly when the FSM is in IDLE.
   assign w_accept   = r_load_ready & load_valid;
   assign w_beat     = r_out_valid & out_ready;
   assign w_res_en   = w_beat && (r_state == S_DATA);
   // Residue including the bit being accepted now; needed to emit the
   // first check bit in the same cycle the last data bit is taken.
   assign w_res_next = mod3_next(w_residue, r_out);

   mod3_residue u_residue (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_accept),
      .i_enable  (w_res_en),
      .i_bit     (r_out),
      .o_residue (w_residue)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_shift      <= '0;
         r_count      <= '0;
         r_out        <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_check  <= 1'b0;
         r_out_last   <= 1'b0;
         r_load_ready <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (load_valid) begin
                  r_shift      <= load_data;
                  r_out        <= load_data[WIDTH-1];
                  r_count      <= CW'(WIDTH - 1);
                  r_out_valid  <= 1'b1;
                  r_load_ready <= 1'b0;
                  r_state      <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_beat) begin
                  if (r_count != '0) begin
                     // r_shift[WIDTH-1] is the bit being accepted now.
                     r_out   <= r_shift[WIDTH-2];
                     r_shift <= r_shift << 1;
                     r_count <= r_count - 1'b1;
                  end else begin
                     r_out       <= w_res_next[1];
                     r_out_check <= 1'b1;
                     r_state     <= S_CHK1;
                  end
               end
            end
            S_CHK1: begin
               if (w_beat) begin
                  r_out      <= w_residue[0];
                  r_out_last <= 1'b1;
                  r_state    <= S_CHK0;
               end
            end
            default: begin // S_CHK0
               if (w_beat) begin
                  r_out        <= 1'b0;
                  r_out_valid  <= 1'b0;
                  r_out_check  <= 1'b0;
                  r_out_last   <= 1'b0;
                  r_load_ready <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign load_ready = r_load_ready;
   assign out        = r_out;
   assign out_valid  = r_out_valid;
   assign out_check  = r_out_check;
   assign out_last   = r_out_last;
   assign residue    = w_residue;

endmodule

// File: doc/serial_mod3_tx.md
Name: serial_mod3_tx

Overview:
- Transmitter for the serial divisibility-by-3 state machine (input bit `in`, 2-bit state `currstate`/`nextstate`).
- Accepts a parallel word on a valid/ready load handshake and shifts it out MSB-first, one bit per accepted beat.
- Tracks the mod-3 residue of the emitted bits using the same transition function as the receiver.
- Appends the final residue as two check bits, so the receiver's end state can be checked against the trailer.

Parameters:
- WIDTH, 8, data word width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- rst  input  1  asynchronous active-high reset.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word (IDLE only).
- load_data  input  WIDTH  word to transmit, MSB sent first.
- out  output  1  current serial bit.
- out_valid  output  1  out holds a valid bit.
- out_ready  input  1  sink accepts out this cycle.
- out_check  output  1  current bit is a check (trailer) bit.
- out_last  output  1  current bit is the final check bit of the frame.
- residue  output  2  running residue of data bits accepted so far in this frame (0..2).

Behaviour:
- Reset (async, rst=1): state=IDLE, load_ready=1, out=0, out_valid=0, out_check=0, out_last=0, residue=0, bit counter=0, shift register=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Transition function, shared with the receiver: r' = (2r + b) mod 3.
  - r=0: b=0 -> 0, b=1 -> 1.
  - r=1: b=0 -> 2, b=1 -> 0.
  - r=2: b=0 -> 1, b=1 -> 2.
  - Encoding 3 is never produced.
- States: IDLE, DATA, CHK1, CHK0.
- IDLE:
  - load_ready=1, out_valid=0.
  - On load_valid=1: capture load_data, clear residue to 0, set count=WIDTH-1, go to DATA.
  - Next cycle: out=load_data[WIDTH-1], out_valid=1, load_ready=0.
  - Load latency is one cycle.
- Beat: a cycle with out_valid=1 and out_ready=1.
  - With out_ready=0, out, out_check, out_last and residue hold unchanged, indefinitely.
- DATA: on each beat, residue updates with the bit just accepted.
  - If count>0: shift to the next lower bit, decrement count.
  - If count==0: go to CHK1; out = bit 1 of the updated residue, out_check=1.
- CHK1: on a beat, go to CHK0; out = residue bit 0, out_last=1.
- CHK0: on a beat, go to IDLE; out_valid, out_check and out_last clear, load_ready=1 on the next cycle.
- Frame timing:
  - A frame is WIDTH+2 beats.
  - Minimum spacing between load accepts is WIDTH+3 cycles.
  - There is no back-to-back overlap.
- load_valid outside IDLE is ignored; load_data is not sampled.
- residue is frozen during CHK1/CHK0 and is cleared on the next load accept.
- Reset mid-frame:
  - Immediately forces the reset values; the partial frame is discarded.
  - No check bits are emitted for the partial frame.
- WIDTH=2 boundary: DATA lasts exactly 2 beats; the counter width is clog2(WIDTH).

Decomposition:
- Shared package: state encoding (IDLE/DATA/CHK1/CHK0), residue constants R0=2'd0, R1=2'd1, R2=2'd2.
- Shared package: a function mod3_next(r,b) implementing the transition table. The receiver-side state machine reuses the same function.
- One sub-module is natural: mod3_residue, a registered residue tracker with clear/enable/bit inputs and a 2-bit output.
- The shift register and control FSM stay in the top.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 20 ns, release, no load.
  - Required: load_ready=1, out_valid=0, residue=0 held for 10 cycles.
- Basic frame, WIDTH=8, out_ready=1, load 8'h07:
  - Required out: 0,0,0,0,0,1,1,1, then check bits 0,1.
  - Required residue after each data beat: 0,0,0,0,0,1,0,1.
  - Required: out_last on beat 10, load_ready high again 1 cycle later.
- Residue 2, load 8'hFE (254):
  - Required: check bits 1,0, out_check=1 on beats 9-10 only.
- Residue 0, load 8'h0C (12):
  - Required residue sequence: 0,0,0,0,1,0,0,0.
  - Required: check bits 0,0.
- Backpressure: load 8'hFE, drop out_ready for 3 cycles at data beat 4 and for 2 cycles at CHK1.
  - Required: out, out_check and residue stable while stalled.
  - Required: bit sequence identical to the unstalled run.
- Reset mid-frame and ignored loads:
  - Stimulus: assert rst at data beat 5, then load 8'h07.
  - Required: immediate reset values, no check bits from the aborted frame, new frame correct.
  - Stimulus: pulse load_valid with 8'hAA during DATA.
  - Required: it is ignored and the output stream is unchanged.
